imem_loader: RTL

//  Write-side counterpart of the byte-addressed instruction memory. Accepts 32-bit program

---
 rtl/imem_pkg.sv | 28 ++
 rtl/imem_word_serializer.sv | 49 ++++
 rtl/imem_loader.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared types and helpers for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;

    // Loader session states.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_WORD = 2'd1,
        ST_WRITE     = 2'd2,
        ST_DONE      = 2'd3
    } ld_state_e;

    // Big-endian lane select: lane 0 is the most significant byte, matching fetch order.
    function automatic logic [7:0] byte_lane(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] lane;
        case (idx)
            2'd0:    lane = word[31:24];
            2'd1:    lane = word[23:16];
            2'd2:    lane = word[15:8];
            default: lane = word[7:0];
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/imem_word_serializer.sv
// Holds one program word and walks its bytes MSB-first, flagging the final lane.
// Latency: load takes effect on the next edge; one lane per advance.
// Backpressure: none; the owning FSM decides when to load and advance.
module imem_word_serializer
    import imem_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic [31:0] word_i,
    input  logic        last_i,
    input  logic        advance_i,
    output logic [1:0]  cnt_o,
    output logic [1:0]  next_idx_o,
    output logic [7:0]  next_lane_o,
    output logic        last_byte_o,
    output logic        word_last_o
);

    logic [31:0] word_q;
    logic [1:0]  cnt_q;
    logic        last_q;

    // Word, session-last flag and byte counter; a load restarts the count at lane 0.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else if (load_i) begin
            word_q <= word_i;
            cnt_q  <= '0;
            last_q <= last_i;
        end else if (advance_i) begin
            cnt_q  <= cnt_q + 2'd1;
        end
    end

    // The owner registers its byte bus one cycle ahead, so it needs the lane after the current one.
    always_comb begin
        next_idx_o  = cnt_q + 2'd1;
        next_lane_o = byte_lane(word_q, next_idx_o);
    end

    assign cnt_o       = cnt_q;
    assign last_byte_o = (cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_last_o = last_q;

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit program words into a byte-wide instruction memory, big-endian, one byte per cycle.
// Latency: first byte write 1 cycle after the word handshake; 5 cycles per word.
// Backpressure: word_ready_o only in WAIT_WORD; optional checksum under IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int ADDR_W      = 5
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [31:0]       word_data_i,
    input  logic              word_valid_i,
    input  logic              word_last_i,
    output logic              word_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_overflow_o,
    output logic [31:0]       checksum_o
);

    // The pointer carries one extra bit so an exact fill can reach DEPTH_BYTES without wrapping.
    localparam int PTR_W = ADDR_W + 1;
    localparam int CMP_W = ADDR_W + 2;

    ld_state_e         state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              err_q, err_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;

    logic              ser_load;
    logic              ser_adv;
    logic [1:0]        ser_cnt;
    logic [1:0]        ser_next_idx;
    logic [7:0]        ser_next_lane;
    logic              ser_last_byte;
    logic              ser_word_last;
    logic              cs_clr;
    logic              cs_add;
    logic              word_overflows;
    logic [1:0]        unused_base_lsbs;
    logic [1:0]        unused_ser_cnt;

    assign unused_base_lsbs = base_addr_i[1:0];
    assign unused_ser_cnt   = ser_cnt;

    imem_word_serializer u_ser (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (ser_load),
        .word_i      (word_data_i),
        .last_i      (word_last_i),
        .advance_i   (ser_adv),
        .cnt_o       (ser_cnt),
        .next_idx_o  (ser_next_idx),
        .next_lane_o (ser_next_lane),
        .last_byte_o (ser_last_byte),
        .word_last_o (ser_word_last)
    );

    // A word is refused when its last byte would land at or beyond DEPTH_BYTES.
    assign word_overflows = ({1'b0, ptr_q} + CMP_W'(BYTES_PER_WORD)) > CMP_W'(DEPTH_BYTES);

    // State register; reset abandons any session without a done pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus the next values of the registered memory port.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        ser_load    = 1'b0;
        ser_adv     = 1'b0;
        cs_clr      = 1'b0;
        cs_add      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_WAIT_WORD;
                    ptr_d   = {1'b0, base_addr_i[ADDR_W-1:2], 2'b00};
                    err_d   = 1'b0;
                    cs_clr  = 1'b1;
                end
            end
            ST_WAIT_WORD: begin
                if (word_valid_i) begin
                    cs_add = 1'b1;
                    if (word_overflows) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        ser_load    = 1'b1;
                        state_d     = ST_WRITE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q[ADDR_W-1:0];
                        mem_wdata_d = byte_lane(word_data_i, 2'd0);
                    end
                end
            end
            ST_WRITE: begin
                ser_adv = 1'b1;
                if (ser_last_byte) begin
                    ptr_d   = ptr_q + PTR_W'(BYTES_PER_WORD);
                    state_d = ser_word_last ? ST_DONE : ST_WAIT_WORD;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ptr_q[ADDR_W-1:0] + ADDR_W'(ser_next_idx);
                    mem_wdata_d = ser_next_lane;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Session pointer, sticky overflow flag and the registered byte write port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q       <= '0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q;

    // Running sum of every accepted word, including one refused for overflow.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (cs_clr) begin
            checksum_q <= '0;
        end else if (cs_add) begin
            checksum_q <= checksum_q + word_data_i;
        end
    end

    assign checksum_o = checksum_q;
`else
    logic unused_cs;

    assign unused_cs  = cs_clr ^ cs_add;
    assign checksum_o = '0;
`endif

    assign word_ready_o   = (state_q == ST_WAIT_WORD);
    assign busy_o         = (state_q != ST_IDLE);
    assign done_o         = (state_q == ST_DONE);
    assign err_overflow_o = err_q;
    assign mem_we_o       = mem_we_q;
    assign mem_addr_o     = mem_addr_q;
    assign mem_wdata_o    = mem_wdata_q;

endmodule
